// File: rtl/sort_sequencer_if.sv
// Stream bundle for sort_sequencer: word input, sorted word output and busy flag.
interface sort_sequencer_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/sort_sequencer.sv
// Sequential odd-even transposition sorter: load N words, sort with one comparator, stream out ascending.
// Optional SORT_SEQ_EARLY_EXIT_EN ends the sort after the first odd phase whose phase pair made no swap.
module sort_sequencer #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             rst,
    sort_sequencer_if.slave  bus
);
    localparam int unsigned IW          = (N > 2) ? $clog2(N) : 1;
    localparam int unsigned LAST_P      = (N > 2) ? N - 1 : 0;
    localparam int unsigned J_EVEN_LAST = N - 2;
    localparam int unsigned J_ODD_LAST  = (N > 2) ? N - 3 : 0;

    typedef enum logic [1:0] {LOAD, SORT, UNLOAD} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  r_q [N];
    logic [IW-1:0] idx_q, j_q, phase_q, jp1;
    logic          done_q;

    logic          in_ready_q, out_valid_q, busy_q;
    logic [W-1:0]  out_data_q;
    logic          in_ready_d, out_valid_d, busy_d;
    logic [W-1:0]  out_data_d;

    logic          in_fire, out_fire, last_word, odd_phase, phase_end;
    logic          sorting, swap, early_exit, last_cmp;
    logic [W-1:0]  lo, hi;

    assign in_fire   = bus.in_valid && in_ready_q;
    assign out_fire  = out_valid_q && bus.out_ready;
    assign last_word = (idx_q == IW'(N - 1));
    assign sorting   = (state_q == SORT) && !done_q;
    assign odd_phase = phase_q[0];
    assign jp1       = j_q + IW'(1);
    assign lo        = r_q[j_q];
    assign hi        = r_q[jp1];
    // Borrow-out of hi - lo says hi < lo; equal words stay put, keeping the sort stable.
    assign swap      = 1'(({1'b0, hi} - {1'b0, lo}) >> W);
    assign phase_end = odd_phase ? (j_q == IW'(J_ODD_LAST)) : (j_q == IW'(J_EVEN_LAST));
    assign last_cmp  = ((phase_q == IW'(LAST_P)) && phase_end) || early_exit;

`ifdef SORT_SEQ_EARLY_EXIT_EN
    logic swapped_q, swapped_d;
    // Flag restarts on the first compare of each even phase and spans the following odd phase.
    assign swapped_d  = (!odd_phase && (j_q == '0)) ? swap : (swapped_q || swap);
    assign early_exit = odd_phase && phase_end && !swapped_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          swapped_q <= 1'b0;
        else if (sorting) swapped_q <= swapped_d;
    end
`else
    assign early_exit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (in_fire && last_word)  state_d = SORT;
            SORT:    if (done_q)                state_d = UNLOAD;
            UNLOAD:  if (out_fire && last_word) state_d = LOAD;
            default:                            state_d = LOAD;
        endcase
    end

    // Next values of the registered outputs; r[0] is presented once the last swap has settled.
    always_comb begin
        in_ready_d  = (state_d == LOAD);
        out_valid_d = (state_d == UNLOAD);
        busy_d      = (state_d == SORT);
        out_data_d  = out_data_q;
        if ((state_q == SORT) && done_q)
            out_data_d = r_q[0];
        else if (out_fire && !last_word)
            out_data_d = r_q[idx_q + IW'(1)];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) r_q[i] <= '0;
            idx_q   <= '0;
            j_q     <= '0;
            phase_q <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (in_fire) begin
                        r_q[idx_q] <= bus.in_data;
                        idx_q      <= last_word ? '0 : idx_q + IW'(1);
                    end
                end
                SORT: begin
                    if (!done_q) begin
                        if (swap) begin
                            r_q[j_q] <= hi;
                            r_q[jp1] <= lo;
                        end
                        if (last_cmp) begin
                            done_q <= 1'b1;
                        end else if (phase_end) begin
                            phase_q <= phase_q + IW'(1);
                            j_q     <= odd_phase ? IW'(0) : IW'(1);
                        end else begin
                            j_q <= j_q + IW'(2);
                        end
                    end else begin
                        done_q  <= 1'b0;
                        phase_q <= '0;
                        j_q     <= '0;
                    end
                end
                UNLOAD: begin
                    if (out_fire) idx_q <= last_word ? '0 : idx_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
endmodule
